vid_pattern_source: RTL
=======================

# vid_pattern_source

Video stream transmitter that produces the pixel-stream interface consumed by the edge-detection pipeline: `valid`/`data` qualified by `hsync` (line-active window) and `vsync` (frame-active window). It generates the frame timing itself: active pixels, horizontal blanking and vertical blanking. It fills each active pixel from a selectable test pattern. It sits at the head of the video chain and drives the filter input for bring-up, regression and throughput testing without a camera.

## Interface
Parameters:
- `VIDEO_WIDTH`, default 1280, active pixels per line.
- `VIDEO_HEIGHT`, default 960, active lines per frame.
- `H_BLANK`, default 160, blank pixel slots per line (≥1).
- `V_BLANK`, default 45, blank lines per frame (≥1).
- `VIDEO_DATA_WIDTH`, default 8, pixel width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-low.
- `enable`  in  1  run request; sampled only at frame boundaries.
- `pix_ce`  in  1  pixel-slot enable; timing advances only when high.
- `pattern_sel`  in  2  pattern code; latched at frame start.
- `vid_out_valid`  out  1  pixel valid.
- `vid_out_data`  out  `VIDEO_DATA_WIDTH`  pixel value.
- `vid_out_hsync`  out  1  high for the whole active-pixel window of a line.
- `vid_out_vsync`  out  1  high from the first active line through the end of the last line's HBLANK.
- `frame_start`  out  1  one-cycle pulse coincident with pixel (0,0).
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- FSM states:
  - IDLE → ACTIVE when `enable`=1 (x=0, y=0, `pattern_sel` latched).
  - ACTIVE → HBLANK after `VIDEO_WIDTH` pixel slots.
  - HBLANK → ACTIVE (y+1) after `H_BLANK` slots if y<`VIDEO_HEIGHT`-1, else → VBLANK.
  - VBLANK lasts `V_BLANK`×(`VIDEO_WIDTH`+`H_BLANK`) slots, then → ACTIVE (new frame, relatch pattern) if `enable`=1, else → IDLE.
- A pixel slot is one cycle with `pix_ce`=1. Counters x, y and the blank counters hold when `pix_ce`=0.
- Deasserting `enable` mid-frame has no effect until the frame (including VBLANK) completes. Frames are atomic.
- `pattern_sel` changes mid-frame are ignored until the next frame start.
- Patterns, all arithmetic truncated to `VIDEO_DATA_WIDTH`:
  - 0: x (horizontal ramp, wraps).
  - 1: y (vertical ramp).
  - 2: all-ones if (x[5]^y[5]) else 0 (32-pixel checkerboard).
  - 3: x+y (diagonal).
- `vid_out_data` is 0 whenever `vid_out_valid`=0.

## Timing
- All outputs are registered. Reset values: `vid_out_valid`, `vid_out_hsync`, `vid_out_vsync`, `frame_start` and `busy` are 0, `vid_out_data` is 0, FSM is IDLE, counters are 0.
- Reset asserted mid-frame returns to IDLE on the next edge. No partial-line completion.
- Latency: a cycle in ACTIVE with `pix_ce`=1 produces `vid_out_valid`=1 with that slot's pixel on the next cycle.
- `vid_out_hsync` = registered (state==ACTIVE). It stays high across `pix_ce` gaps, so the line window lasts ≥`VIDEO_WIDTH` cycles.
- `vid_out_vsync` = registered (state∈{ACTIVE, HBLANK}).
- `enable` rising in IDLE puts the FSM in ACTIVE on the next cycle. The first pixel appears one cycle after the first `pix_ce`=1 in ACTIVE.
- Back-to-back frames: VBLANK last slot → ACTIVE (0,0) with no extra idle cycle.
- Each frame carries exactly `VIDEO_WIDTH`×`VIDEO_HEIGHT` valid pixels and `VIDEO_HEIGHT` hsync windows.

## Structure
- Shared package `vid_pkg`: FSM state enum (IDLE, ACTIVE, HBLANK, VBLANK) and pattern codes (`PAT_HRAMP`, `PAT_VRAMP`, `PAT_CHECK`, `PAT_DIAG`).
- Counter widths come from `$clog2` of `VIDEO_WIDTH`+`H_BLANK` and of `VIDEO_HEIGHT`+`V_BLANK`.
- One combinational sub-module, `vid_pattern_gen`, maps (x, y, pattern) to a pixel value. The timing FSM and output registers live in the top.

## Test plan
All cases use `VIDEO_WIDTH`=8, `VIDEO_HEIGHT`=4, `H_BLANK`=2, `V_BLANK`=1.
- Reset mid-line: `rst`=0 during ACTIVE at x=3 → next cycle all outputs 0, `busy`=0. Releasing reset with `enable`=1 restarts at pixel (0,0).
- Continuous run: `pix_ce`=1, `enable`=1, pattern 0 → each line shows 8 valid pixels 0..7 under 8-cycle hsync, then 2 blank cycles. vsync spans 40 cycles. VBLANK is 10 cycles. Frame period is 50 cycles. `frame_start` pulses once per frame.
- Throttled run: `pix_ce` alternating 1/0 → same 32 pixel values in order. Hsync windows are 16 cycles. Frame period is 100 cycles.
- Frame-atomic stop: drop `enable` at line 1 → frame completes all 32 pixels plus VBLANK, then IDLE. `busy` falls after the 50th slot.
- Pattern latch: switch `pattern_sel` 0→2 mid-frame → current frame stays a ramp. Next frame pixel (0,0)=0. Pattern 3 at (7,3) yields 10.
- Sobel integration: source drives the edge-detection top with a checkerboard at `VIDEO_WIDTH`=64 → output valid count per frame and non-zero gradients occur only at the 32-pixel boundaries.

Source files
------------

// File: rtl/vid_pattern_source_pkg.sv
// vid_pkg: shared FSM states and test-pattern codes for the video pattern source
package vid_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_e;
  typedef enum logic [1:0] {PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_DIAG} pat_e;
endpackage

// File: rtl/vid_pattern_source_if.sv
// vid_pattern_source_if: registered pixel stream from the source to the filter input
interface vid_pattern_source_if #(parameter int DW = 8);
  logic          valid;
  logic [DW-1:0] data;
  logic          hsync;
  logic          vsync;
  logic          frame_start;
  modport master (output valid, data, hsync, vsync, frame_start);
  modport slave  (input valid, data, hsync, vsync, frame_start);
endinterface

// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen: maps pixel coordinates and a pattern code to a pixel value
module vid_pattern_gen
  import vid_pkg::*;
#(
  parameter int XW = 4,
  parameter int YW = 3,
  parameter int DW = 8
) (
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  pat_e          pat_i,
  output logic [DW-1:0] pix_o
);
  logic [31:0] xe, ye;
  // widen first so bit 5 exists for the checkerboard even with narrow counters
  always_comb begin
    xe = 32'(x_i);
    ye = 32'(y_i);
    pix_o = pat_i == PAT_HRAMP ? DW'(xe) :
            pat_i == PAT_VRAMP ? DW'(ye) :
            pat_i == PAT_CHECK ? {DW{xe[5] ^ ye[5]}} : DW'(xe + ye);
  end
endmodule

// File: rtl/vid_pattern_source.sv
// vid_pattern_source: frame-timing FSM driving a test-pattern pixel stream
module vid_pattern_source
  import vid_pkg::*;
#(
  parameter int VIDEO_WIDTH      = 1280,
  parameter int VIDEO_HEIGHT     = 960,
  parameter int H_BLANK          = 160,
  parameter int V_BLANK          = 45,
  parameter int VIDEO_DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        pix_ce,
  input  logic [1:0]                  pattern_sel,
  vid_pattern_source_if.master        vid_out,
  output logic                        busy
);
  localparam int LINE = VIDEO_WIDTH + H_BLANK;
  localparam int XW = $clog2(LINE);
  localparam int YW = $clog2(VIDEO_HEIGHT + V_BLANK);
  localparam int DW = VIDEO_DATA_WIDTH;
  state_e state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  pat_e pat_q, pat_d;
  logic [DW-1:0] pix, data_q;
  logic valid_q, hsync_q, vsync_q, fs_q, busy_q;
  logic line_end, act_ce;
  vid_pattern_gen #(.XW(XW), .YW(YW), .DW(DW)) u_gen (
    .x_i  (x_q),
    .y_i  (y_q),
    .pat_i(pat_q),
    .pix_o(pix)
  );
  // x runs across the whole line (active then blank); in VBLANK y counts blank lines
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    pat_d = pat_q;
    line_end = x_q == XW'(LINE - 1);
    act_ce = state_q == ACTIVE && pix_ce;
    case (state_q)
      IDLE: if (enable) begin
        state_d = ACTIVE;
        x_d = '0;
        y_d = '0;
        pat_d = pat_e'(pattern_sel);
      end
      ACTIVE: if (pix_ce) begin
        x_d = x_q + XW'(1);
        state_d = x_q == XW'(VIDEO_WIDTH - 1) ? HBLANK : ACTIVE;
      end
      HBLANK: if (pix_ce) begin
        x_d = line_end ? '0 : x_q + XW'(1);
        if (line_end) begin
          y_d = y_q == YW'(VIDEO_HEIGHT - 1) ? '0 : y_q + YW'(1);
          state_d = y_q == YW'(VIDEO_HEIGHT - 1) ? VBLANK : ACTIVE;
        end
      end
      VBLANK: if (pix_ce) begin
        x_d = line_end ? '0 : x_q + XW'(1);
        if (line_end && y_q == YW'(V_BLANK - 1)) begin
          y_d = '0;
          state_d = enable ? ACTIVE : IDLE;
          pat_d = enable ? pat_e'(pattern_sel) : pat_q;
        end else if (line_end) y_d = y_q + YW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // state, counters and registered stream outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      pat_q <= PAT_HRAMP;
      valid_q <= 1'b0;
      data_q <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      fs_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      pat_q <= pat_d;
      valid_q <= act_ce;
      data_q <= act_ce ? pix : '0;
      hsync_q <= state_q == ACTIVE;
      vsync_q <= state_q == ACTIVE || state_q == HBLANK;
      fs_q <= act_ce && x_q == '0 && y_q == '0;
      busy_q <= state_d != IDLE;
    end
  end
  assign vid_out.valid = valid_q;
  assign vid_out.data = data_q;
  assign vid_out.hsync = hsync_q;
  assign vid_out.vsync = vsync_q;
  assign vid_out.frame_start = fs_q;
  assign busy = busy_q;
endmodule
